// File: rtl/pc_ctrl.sv
// Program-counter sequencer: arbitrates trap/irq/mret/branch redirects and memory stalls
// into one-hot pc controls, squashes wrong-path stages after each redirect.
module pc_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             imem_ready_i,
    input  logic             dmem_busy_i,
    input  logic             instr_valid_i,
    input  logic             branch_i,
    input  logic             mret_i,
    input  logic             exc_i,
    input  logic [3:0]       exc_cause_i,
    input  logic             irq_i,
    output logic             stall_o,
    output logic             incr_pc_o,
    output logic             exception_o,
    output logic             ret_o,
    output logic             load_arith_o,
    output logic             flush_o,
    output logic             irq_ack_o,
    output logic [31:0]      mcause_o,
    output logic [CNT_W-1:0] redirect_cnt_o
);

    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [FW-1:0]     fcnt_q, fcnt_d;
    logic [31:0]       mcause_q, mcause_d;
    logic [CNT_W-1:0]  redir_q, redir_d;

    logic take_exc, take_irq, take_ret, take_br, redirect;

    // Interrupts wait out a load/store; synchronous traps abort it.
    assign take_exc = exc_i & instr_valid_i;
    assign take_irq = irq_i & ~dmem_busy_i;
    assign take_ret = mret_i & instr_valid_i & ~dmem_busy_i;
    assign take_br  = branch_i & instr_valid_i & ~dmem_busy_i;

    always_comb begin
        state_d      = state_q;
        fcnt_d       = fcnt_q;
        mcause_d     = mcause_q;
        redir_d      = redir_q;
        stall_o      = 1'b0;
        incr_pc_o    = 1'b0;
        exception_o  = 1'b0;
        ret_o        = 1'b0;
        load_arith_o = 1'b0;
        flush_o      = 1'b0;
        irq_ack_o    = 1'b0;
        redirect     = 1'b0;
        case (state_q)
            ST_BOOT: begin
                flush_o = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (take_exc) begin
                    exception_o = 1'b1;
                    mcause_d    = {28'b0, exc_cause_i};
                    redirect    = 1'b1;
                end else if (take_irq) begin
                    exception_o = 1'b1;
                    irq_ack_o   = 1'b1;
                    mcause_d    = 32'h8000_000B;
                    redirect    = 1'b1;
                end else if (take_ret) begin
                    ret_o    = 1'b1;
                    redirect = 1'b1;
                end else if (take_br) begin
                    load_arith_o = 1'b1;
                    redirect     = 1'b1;
                end else if (dmem_busy_i || !imem_ready_i) begin
                    stall_o = 1'b1;
                end else begin
                    incr_pc_o = 1'b1;
                end
                if (redirect) begin
                    redir_d = redir_q + CNT_W'(1);
                    fcnt_d  = FLUSH_LAST;
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Squash window only advances on accepted fetches.
                flush_o   = 1'b1;
                incr_pc_o = imem_ready_i;
                stall_o   = ~imem_ready_i;
                if (imem_ready_i) begin
                    if (fcnt_q == '0) state_d = ST_RUN;
                    else              fcnt_d  = fcnt_q - FW'(1);
                end
            end
            default: begin
                flush_o = 1'b1;
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_BOOT;
            fcnt_q   <= '0;
            mcause_q <= '0;
            redir_q  <= '0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            mcause_q <= mcause_d;
            redir_q  <= redir_d;
        end
    end

    assign mcause_o       = mcause_q;
    assign redirect_cnt_o = redir_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Randomized + directed bench for pc_ctrl against a cycle-level behavioural model
// (built with a 4-bit redirect counter so wrap-around is reachable).
module tb_pc_ctrl;

    localparam int FC = 2;
    localparam int CW = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          imem_ready_i = 1'b0, dmem_busy_i = 1'b0, instr_valid_i = 1'b0;
    logic          branch_i = 1'b0, mret_i = 1'b0, exc_i = 1'b0, irq_i = 1'b0;
    logic [3:0]    exc_cause_i = 4'd0;
    logic          stall_o, incr_pc_o, exception_o, ret_o, load_arith_o, flush_o, irq_ack_o;
    logic [31:0]   mcause_o;
    logic [CW-1:0] redirect_cnt_o;

    pc_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .imem_ready_i(imem_ready_i), .dmem_busy_i(dmem_busy_i), .instr_valid_i(instr_valid_i),
        .branch_i(branch_i), .mret_i(mret_i), .exc_i(exc_i), .exc_cause_i(exc_cause_i),
        .irq_i(irq_i),
        .stall_o(stall_o), .incr_pc_o(incr_pc_o), .exception_o(exception_o), .ret_o(ret_o),
        .load_arith_o(load_arith_o), .flush_o(flush_o), .irq_ack_o(irq_ack_o),
        .mcause_o(mcause_o), .redirect_cnt_o(redirect_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
    endtask

    // Model: phase 0=just out of reset, 1=running, 2=squashing wrong path
    int          m_phase;
    int          m_ready_left;   // accepted fetches still to be squashed
    int unsigned m_cause;
    int unsigned m_redirs;

    task automatic model_reset();
        m_phase = 0; m_ready_left = 0; m_cause = 0; m_redirs = 0;
    endtask

    task automatic drive(input bit rdy, input bit busy, input bit vld, input bit br,
                         input bit mr, input bit ex, input int cause, input bit irq);
        imem_ready_i = rdy; dmem_busy_i = busy; instr_valid_i = vld; branch_i = br;
        mret_i = mr; exc_i = ex; exc_cause_i = 4'(cause); irq_i = irq;
    endtask

    // Called at a falling edge with inputs already driven; checks, then advances one clock.
    task automatic cycle();
        bit e_stall, e_incr, e_exc, e_ret, e_ld, e_flush, e_ack;
        int kind;   // 0 none, 1 trap, 2 irq, 3 mret, 4 branch
        #1;
        e_stall = 0; e_incr = 0; e_exc = 0; e_ret = 0; e_ld = 0; e_flush = 0; e_ack = 0;
        kind = 0;
        if (rst_i) model_reset();
        if (rst_i || m_phase == 0) begin
            e_flush = 1;
        end else if (m_phase == 2) begin
            e_flush = 1;
            e_incr  = imem_ready_i;
            e_stall = !imem_ready_i;
        end else begin
            if (exc_i && instr_valid_i)                          kind = 1;
            else if (irq_i && !dmem_busy_i)                      kind = 2;
            else if (mret_i && instr_valid_i && !dmem_busy_i)    kind = 3;
            else if (branch_i && instr_valid_i && !dmem_busy_i)  kind = 4;
            e_exc = (kind == 1 || kind == 2);
            e_ack = (kind == 2);
            e_ret = (kind == 3);
            e_ld  = (kind == 4);
            if (kind == 0) begin
                if (dmem_busy_i || !imem_ready_i) e_stall = 1;
                else                              e_incr  = 1;
            end
        end
        check("stall", 32'(stall_o), 32'(e_stall));
        check("incr", 32'(incr_pc_o), 32'(e_incr));
        check("exception", 32'(exception_o), 32'(e_exc));
        check("ret", 32'(ret_o), 32'(e_ret));
        check("load_arith", 32'(load_arith_o), 32'(e_ld));
        check("flush", 32'(flush_o), 32'(e_flush));
        check("irq_ack", 32'(irq_ack_o), 32'(e_ack));
        check("mcause", mcause_o, m_cause);
        check("redir_cnt", 32'(redirect_cnt_o), m_redirs);
        @(posedge clk_i);
        if (!rst_i) begin
            if (m_phase == 0) m_phase = 1;
            else if (m_phase == 2) begin
                if (imem_ready_i) m_ready_left--;
                if (m_ready_left == 0) m_phase = 1;
            end else if (kind != 0) begin
                if (kind == 1) m_cause = 32'(exc_cause_i);
                if (kind == 2) m_cause = 32'h8000_000B;
                m_redirs     = (m_redirs + 1) % (1 << CW);
                m_ready_left = FC;
                m_phase      = 2;
            end
        end
        @(negedge clk_i);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 0);
            cycle();
        end
    endtask

    initial begin
        model_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        cycle();                       // reset values while held
        cycle();
        rst_i = 1'b0;

        // boot cycle then plain increments
        idle(4);

        // single branch: pulse, two ready flush cycles
        drive(1, 0, 1, 1, 0, 0, 0, 0); cycle();
        idle(4);

        // trap + irq + branch together: trap wins, irq held until after flush
        drive(1, 0, 1, 1, 0, 1, 2, 1); cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 1); cycle();
        end
        idle(3);

        // memory busy with branch held: stalls, then branch taken
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 1, 0, 0, 0, 0); cycle();
        end
        drive(1, 0, 1, 1, 0, 0, 0, 0); cycle();
        // branch during flush ignored; fetch not ready stretches the flush
        drive(0, 0, 1, 1, 0, 0, 0, 0); cycle();
        drive(0, 0, 1, 1, 0, 0, 0, 0); cycle();
        drive(1, 0, 1, 1, 0, 0, 0, 0); cycle();
        drive(1, 0, 1, 1, 0, 0, 0, 0); cycle();
        idle(2);

        // mret redirect
        drive(1, 0, 1, 0, 1, 0, 0, 0); cycle();
        idle(3);

        // enough branches to wrap the 4-bit redirect counter
        for (int i = 0; i < 18; i++) begin
            drive(1, 0, 1, 1, 0, 0, 0, 0); cycle();
            idle(2);
        end

        // reset in the middle of a flush
        drive(1, 0, 1, 1, 0, 0, 0, 0); cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0); cycle();
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        idle(3);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 2,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2,
                  $urandom_range(0, 9) < 1, $urandom_range(0, 9) < 1,
                  int'($urandom_range(0, 15)), $urandom_range(0, 9) < 1);
            if ($urandom_range(0, 199) == 0) rst_i = 1'b1;
            cycle();
            rst_i = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
